mouse_bus_reader: RTL and testbench
===================================

Name: mouse_bus_reader

Overview:
- Bus initiator that pairs with the memory-mapped mouse bus interface.
- On a mouse interrupt it requests the shared CPU bus, acknowledges the interrupt, and reads the six mouse registers at BASE_ADDR+0..5.
- It presents the six values as one atomic snapshot, so hardware consumers (cursor overlay, LED/7-seg drivers) get mouse state without CPU involvement.

Parameters:
BASE_ADDR, 8'hA0, base of the mouse register window; offsets 0..5 = status, X, Y, scroll, dX, dY
READ_LATENCY, 2, cycles each address is held before BUS_DATA is sampled; legal values >= 2

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
BUS_DATA  inout  8  shared data bus; this block never drives it (constant 8'hZZ), only samples it
BUS_ADDR  output  8  read address; 8'hFF whenever not in a read cycle
BUS_WE  output  1  constant 0 (block is read-only)
BUS_REQ  output  1  bus request to arbiter
BUS_GNT  input  1  bus grant from arbiter
BUS_INTERRUPT_RAISE  input  1  level interrupt from the mouse interface
BUS_INTERRUPT_ACK  output  1  one-cycle acknowledge pulse
MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_SCROLL, MOUSE_DX, MOUSE_DY  output  8 each  snapshot registers
NEW_SAMPLE  output  1  one-cycle pulse when the snapshot updates

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state IDLE; BUS_REQ=0, BUS_INTERRUPT_ACK=0, NEW_SAMPLE=0, BUS_ADDR=8'hFF, all snapshot outputs 8'h00, shadow regs 0, acked flag 0.
- All outputs are registered.
- FSM states: IDLE, REQ, READ, DONE.
- IDLE:
  - RAISE sampled 1 -> REQ.
  - BUS_REQ=1 from the next cycle.
- REQ:
  - BUS_REQ=1; wait for BUS_GNT=1.
  - On GNT, go to READ with idx=0 and lat=0.
  - BUS_ADDR=BASE_ADDR from the first READ cycle.
  - If acked=0: BUS_INTERRUPT_ACK=1 for exactly that first READ cycle, then acked<=1.
- READ:
  - BUS_ADDR=BASE_ADDR+idx, held for READ_LATENCY cycles.
  - On the edge ending the last of those cycles, BUS_DATA is captured into shadow[idx].
  - Then idx++ and lat=0; a new address starts the following cycle.
  - After idx=5 is captured -> DONE.
  - A full read takes 6*READ_LATENCY cycles.
- Grant loss:
  - BUS_GNT sampled 0 in READ -> abort: BUS_ADDR=8'hFF next cycle, return to REQ (BUS_REQ stays 1), idx reset to 0.
  - Partial shadow data is discarded; outputs are untouched; no second ACK (acked stays 1).
- DONE (one cycle):
  - Shadow copied to all six outputs simultaneously; NEW_SAMPLE=1.
  - BUS_REQ=0, BUS_ADDR=8'hFF, acked<=0 -> IDLE.
- Re-raise during a read:
  - RAISE asserted again during READ (new mouse packet after ACK) is not lost: the interface holds it.
  - IDLE sees it on the cycle after DONE and a second transaction follows; minimum gap is 1 IDLE cycle.
- RAISE sampled in REQ/READ/DONE is ignored; the level handshake covers it.
- BUS_WE is always 0 and BUS_DATA is always released, so no contention is possible.
- Reset mid-transaction: immediate return to reset values.
  - Any pending RAISE is re-serviced normally after reset deasserts, including a new ACK.
- Snapshot outputs change only in DONE, never mid-read.

Test Plan:
- Basic read:
  - Stimulus: responder model holds A0..A5 = 08,40,3C,00,05,FB; GNT tied 1; RAISE pulsed until ACK.
  - Response: ACK seen once, coincident with BUS_ADDR=A0. Addresses A0..A5 each held 2 cycles. 12 cycles later NEW_SAMPLE=1 with outputs 08,40,3C,00,05,FB, and BUS_REQ=0 that same cycle.
- Delayed grant:
  - Stimulus: GNT held 0 for 5 cycles after BUS_REQ rises.
  - Response: BUS_ADDR stays FF and ACK stays 0 until GNT. Read sequence then matches the basic case.
- Grant drop mid-read:
  - Stimulus: GNT forced 0 during address A3 for 3 cycles, then back to 1.
  - Response: BUS_ADDR returns to FF; read restarts at A0; no second ACK pulse. Outputs are unchanged until the final NEW_SAMPLE, which carries the correct values.
- Re-raise:
  - Stimulus: RAISE asserted again during the A2 read, with new data A0..A5 = 09,41,3D,01,01,01 after the first read.
  - Response: two NEW_SAMPLE pulses and two ACKs; the second snapshot = 09,41,3D,01,01,01.
- Reset mid-read:
  - Stimulus: RESET high for 1 cycle during A4.
  - Response: next cycle BUS_REQ=0, BUS_ADDR=FF, all outputs 00. With RAISE still high, a fresh transaction with a new ACK starts 1 cycle after reset releases.
- Parameter variant:
  - Stimulus: READ_LATENCY=3, BASE_ADDR=8'hB0.
  - Response: addresses B0..B5, each held 3 cycles; NEW_SAMPLE 18 cycles after the first address cycle.

Source files
------------

// File: rtl/mouse_bus_reader.sv
// Mouse bus reader: on a mouse interrupt, win the shared bus, acknowledge
// the interrupt, read the six mouse registers and publish them together
// as one snapshot with a single-cycle NEW_SAMPLE strobe.
module mouse_bus_reader #(
    parameter logic [7:0] BASE_ADDR    = 8'hA0,
    parameter int         READ_LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    input  logic       BUS_INTERRUPT_RAISE,
    output logic       BUS_INTERRUPT_ACK,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic [7:0] MOUSE_SCROLL,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       NEW_SAMPLE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              LAT_W   = $clog2(READ_LATENCY);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(READ_LATENCY - 1);
    localparam logic [2:0]      IDX_MAX = 3'd5;
    localparam logic [7:0]      ADDR_IDLE = 8'hFF;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             acked_q, acked_d;
    logic             req_q, req_d;
    logic             ack_q, ack_d;
    logic             ns_q, ns_d;
    logic [7:0]       addr_q, addr_d;

    // Strobes from the FSM into the per-register datapath.
    logic             capture_en;
    logic             publish_en;

    logic [7:0] shadow_q [0:5];
    logic [7:0] snap_q   [0:5];

    // The block only ever reads the shared bus.
    assign BUS_DATA = 8'hzz;
    assign BUS_WE   = 1'b0;

    // Next-state logic for the request / read / publish sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        acked_d    = acked_q;
        req_d      = req_q;
        ack_d      = 1'b0;
        ns_d       = 1'b0;
        addr_d     = addr_q;
        capture_en = 1'b0;
        publish_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (BUS_INTERRUPT_RAISE) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                end
            end
            S_REQ: begin
                req_d = 1'b1;
                if (BUS_GNT) begin
                    state_d = S_READ;
                    idx_d   = 3'd0;
                    lat_d   = '0;
                    addr_d  = BASE_ADDR;
                    // Only the first grant of a transaction acknowledges;
                    // a restart after grant loss must not ack again.
                    ack_d   = ~acked_q;
                    acked_d = 1'b1;
                end
            end
            S_READ: begin
                if (!BUS_GNT) begin
                    // Grant lost: drop the bus and restart from offset 0.
                    state_d = S_REQ;
                    addr_d  = ADDR_IDLE;
                    idx_d   = 3'd0;
                    lat_d   = '0;
                end else if (lat_q == LAT_MAX) begin
                    capture_en = 1'b1;
                    lat_d      = '0;
                    if (idx_q == IDX_MAX) begin
                        state_d    = S_DONE;
                        addr_d     = ADDR_IDLE;
                        req_d      = 1'b0;
                        ns_d       = 1'b1;
                        publish_en = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        addr_d = BASE_ADDR + {5'd0, idx_q} + 8'd1;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: begin
                // DONE lasts one cycle; the next interrupt needs a fresh ack.
                state_d = S_IDLE;
                acked_d = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            lat_q   <= '0;
            acked_q <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            ns_q    <= 1'b0;
            addr_q  <= ADDR_IDLE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            acked_q <= acked_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            ns_q    <= ns_d;
            addr_q  <= addr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_reg
            logic hit;
            assign hit = capture_en && (idx_q == 3'(gi));

            // Shadow copy of one mouse register, filled as the read walks.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    shadow_q[gi] <= 8'h00;
                end else if (hit) begin
                    shadow_q[gi] <= BUS_DATA;
                end
            end

            // Published value; the last register is taken straight off the
            // bus so all six appear in the same cycle as NEW_SAMPLE.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    snap_q[gi] <= 8'h00;
                end else if (publish_en) begin
                    snap_q[gi] <= hit ? BUS_DATA : shadow_q[gi];
                end
            end
        end
    endgenerate

    assign BUS_ADDR          = addr_q;
    assign BUS_REQ           = req_q;
    assign BUS_INTERRUPT_ACK = ack_q;
    assign NEW_SAMPLE        = ns_q;
    assign MOUSE_STATUS      = snap_q[0];
    assign MOUSE_X           = snap_q[1];
    assign MOUSE_Y           = snap_q[2];
    assign MOUSE_SCROLL      = snap_q[3];
    assign MOUSE_DX          = snap_q[4];
    assign MOUSE_DY          = snap_q[5];

endmodule

// File: tb/tb_mouse_bus_reader.sv
// Directed bench for mouse_bus_reader: a default instance exercised through
// a mouse-interface responder model, plus a READ_LATENCY=3 / base B0 instance.
module tb_mouse_bus_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst;
    logic       gnt, raise, gnt2, raise2;
    wire  [7:0] bus_data, bus_data2;
    logic [7:0] addr, addr2;
    logic       we, we2, req, req2, ack, ack2, ns, ns2;
    logic [7:0] st, x, y, sc, dx, dy;
    logic [7:0] st2, x2, y2, sc2, dx2, dy2;
    logic [7:0] mem  [0:5];
    logic [7:0] mem2 [0:5];

    wire [47:0] out1 = {st, x, y, sc, dx, dy};
    wire [47:0] out2 = {st2, x2, y2, sc2, dx2, dy2};

    // Mouse register window responders.
    wire [7:0] off1 = addr - 8'hA0;
    wire [7:0] off2 = addr2 - 8'hB0;
    assign bus_data  = (off1 < 8'd6) ? mem[off1[2:0]]  : 8'h00;
    assign bus_data2 = (off2 < 8'd6) ? mem2[off2[2:0]] : 8'h00;

    mouse_bus_reader dut (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr),
        .BUS_WE(we), .BUS_REQ(req), .BUS_GNT(gnt),
        .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack),
        .MOUSE_STATUS(st), .MOUSE_X(x), .MOUSE_Y(y), .MOUSE_SCROLL(sc),
        .MOUSE_DX(dx), .MOUSE_DY(dy), .NEW_SAMPLE(ns)
    );

    mouse_bus_reader #(.BASE_ADDR(8'hB0), .READ_LATENCY(3)) dut2 (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus_data2), .BUS_ADDR(addr2),
        .BUS_WE(we2), .BUS_REQ(req2), .BUS_GNT(gnt2),
        .BUS_INTERRUPT_RAISE(raise2), .BUS_INTERRUPT_ACK(ack2),
        .MOUSE_STATUS(st2), .MOUSE_X(x2), .MOUSE_Y(y2), .MOUSE_SCROLL(sc2),
        .MOUSE_DX(dx2), .MOUSE_DY(dy2), .NEW_SAMPLE(ns2)
    );

    // The mouse interface holds its interrupt until it sees the ack.
    always @(negedge clk) begin
        if (ack === 1'b1)  raise = 1'b0;
        if (ack2 === 1'b1) raise2 = 1'b0;
    end

    // Per-cycle trace of the default instance.
    logic [7:0]  tr_addr [$];
    bit          tr_ack  [$];
    bit          tr_req  [$];
    bit          tr_ns   [$];
    logic [47:0] tr_out  [$];

    task automatic clear_trace();
        tr_addr.delete(); tr_ack.delete(); tr_req.delete();
        tr_ns.delete(); tr_out.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tr_addr.push_back(addr);
        tr_ack.push_back(ack === 1'b1);
        tr_req.push_back(req === 1'b1);
        tr_ns.push_back(ns === 1'b1);
        tr_out.push_back(out1);
    endtask

    task automatic run_until_ns(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (ns === 1'b1) got = 1'b1;
        end
    endtask

    task automatic run_until_addr(input logic [7:0] a, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (addr === a) got = 1'b1;
        end
    endtask

    function automatic int count_ack();
        int c = 0;
        foreach (tr_ack[i]) if (tr_ack[i]) c++;
        return c;
    endfunction

    function automatic int count_ns();
        int c = 0;
        foreach (tr_ns[i]) if (tr_ns[i]) c++;
        return c;
    endfunction

    function automatic int first_bus_cycle();
        foreach (tr_addr[i]) if (tr_addr[i] !== 8'hFF) return i;
        return -1;
    endfunction

    task automatic load_mem(input logic [47:0] v);
        for (int i = 0; i < 6; i++) mem[i] = v[47 - 8*i -: 8];
    endtask

    localparam logic [47:0] DATA_A = 48'h08_40_3C_00_05_FB;
    localparam logic [47:0] DATA_B = 48'h10_20_30_40_50_60;
    localparam logic [47:0] DATA_C = 48'h11_22_33_44_55_66;
    localparam logic [47:0] DATA_D = 48'h09_41_3D_01_01_01;

    task automatic test_reset();
        rst = 1'b1; gnt = 1'b1; raise = 1'b0; gnt2 = 1'b1; raise2 = 1'b0;
        load_mem(DATA_A);
        tick(); tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req); end
        checks++; if (addr !== 8'hFF) begin errors++; $display("FAIL reset_addr got=%h exp=ff", addr); end
        checks++; if (ack !== 1'b0 || ns !== 1'b0) begin errors++; $display("FAIL reset_pulses ack=%b ns=%b exp=0/0", ack, ns); end
        checks++; if (out1 !== 48'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", out1); end
        checks++; if (we !== 1'b0 || we2 !== 1'b0) begin errors++; $display("FAIL reset_we got=%b/%b exp=0/0", we, we2); end
        checks++; if (addr2 !== 8'hFF || req2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 addr=%h req=%b exp=ff/0", addr2, req2); end
        rst = 1'b0;
        tick(); tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit got; int f, n;
        load_mem(DATA_A);
        clear_trace();
        raise = 1'b1;
        run_until_ns(40, got);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_ns_timeout got=0 exp=1"); end
        else begin
            n = tr_ns.size() - 1;
            f = first_bus_cycle();
            checks++; if (count_ack() != 1) begin errors++; $display("FAIL basic_ack_count got=%0d exp=1", count_ack()); end
            checks++; if (!tr_ack[f] || tr_addr[f] !== 8'hA0) begin errors++; $display("FAIL basic_ack_addr ack=%b addr=%h exp=1/a0", tr_ack[f], tr_addr[f]); end
            checks++; if (n - f != 12) begin errors++; $display("FAIL basic_latency got=%0d exp=12", n - f); end
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (tr_addr[f+k] !== 8'hA0 + 8'(k/2)) begin
                    errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", k, tr_addr[f+k], 8'hA0 + 8'(k/2));
                end
            end
            checks++; if (tr_req[n]) begin errors++; $display("FAIL basic_req_at_done got=1 exp=0"); end
            checks++; if (out1 !== DATA_A) begin errors++; $display("FAIL basic_snapshot got=%h exp=%h", out1, DATA_A); end
        end
        $display("test_basic done");
    endtask

    task automatic test_delayed_grant();
        bit got; int f, n, bad;
        repeat (2) tick();
        load_mem(DATA_B);
        gnt = 1'b0;
        clear_trace();
        raise = 1'b1;
        repeat (5) tick();
        checks++; if (!tr_req[0]) begin errors++; $display("FAIL dgnt_req got=0 exp=1"); end
        bad = 0;
        for (int i = 0; i < 5; i++) if (tr_addr[i] !== 8'hFF || tr_ack[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL dgnt_idle_bus bad_cycles=%0d exp=0", bad); end
        gnt = 1'b1;
        run_until_ns(40, got);
        checks++;
        if (!got) begin errors++; $display("FAIL dgnt_ns_timeout got=0 exp=1"); end
        else begin
            n = tr_ns.size() - 1;
            f = first_bus_cycle();
            checks++; if (f != 5) begin errors++; $display("FAIL dgnt_first_addr_cycle got=%0d exp=5", f); end
            checks++; if (count_ack() != 1 || !tr_ack[f]) begin errors++; $display("FAIL dgnt_ack count=%0d exp=1 at A0", count_ack()); end
            checks++; if (n - f != 12) begin errors++; $display("FAIL dgnt_latency got=%0d exp=12", n - f); end
            checks++; if (out1 !== DATA_B) begin errors++; $display("FAIL dgnt_snapshot got=%h exp=%h", out1, DATA_B); end
        end
        $display("test_delayed_grant done");
    endtask

    task automatic test_grant_drop();
        bit got; int c, n, bad;
        repeat (2) tick();
        load_mem(DATA_C);
        clear_trace();
        raise = 1'b1;
        run_until_addr(8'hA3, 40, got);
        checks++;
        if (!got) begin errors++; $display("FAIL gdrop_reach_a3 got=0 exp=1"); end
        else begin
            c = tr_addr.size() - 1;
            gnt = 1'b0;
            repeat (3) tick();
            gnt = 1'b1;
            run_until_ns(40, got);
            checks++;
            if (!got) begin errors++; $display("FAIL gdrop_ns_timeout got=0 exp=1"); end
            else begin
                n = tr_ns.size() - 1;
                checks++; if (tr_addr[c+1] !== 8'hFF) begin errors++; $display("FAIL gdrop_release got=%h exp=ff", tr_addr[c+1]); end
                checks++; if (count_ack() != 1) begin errors++; $display("FAIL gdrop_ack_count got=%0d exp=1", count_ack()); end
                checks++; if (count_ns() != 1) begin errors++; $display("FAIL gdrop_ns_count got=%0d exp=1", count_ns()); end
                bad = 0;
                for (int i = 0; i < n; i++) if (tr_out[i] !== DATA_B) bad++;
                checks++; if (bad != 0) begin errors++; $display("FAIL gdrop_outputs_held bad_cycles=%0d exp=0", bad); end
                checks++; if (tr_addr[n-13] !== 8'hFF || tr_addr[n-12] !== 8'hA0) begin errors++; $display("FAIL gdrop_restart got=%h,%h exp=ff,a0", tr_addr[n-13], tr_addr[n-12]); end
                checks++; if (n - c != 16) begin errors++; $display("FAIL gdrop_timing got=%0d exp=16", n - c); end
                checks++; if (out1 !== DATA_C) begin errors++; $display("FAIL gdrop_snapshot got=%h exp=%h", out1, DATA_C); end
            end
        end
        $display("test_grant_drop done");
    endtask

    task automatic test_back_to_back();
        bit got1, got2; int n1;
        repeat (2) tick();
        load_mem(DATA_A);
        clear_trace();
        raise = 1'b1;
        run_until_addr(8'hA2, 40, got1);
        raise = 1'b1;
        run_until_ns(40, got1);
        n1 = tr_ns.size() - 1;
        load_mem(DATA_D);
        run_until_ns(40, got2);
        checks++;
        if (!got1 || !got2) begin errors++; $display("FAIL rr_ns_timeout got=%b%b exp=11", got1, got2); end
        else begin
            checks++; if (tr_out[n1] !== DATA_A) begin errors++; $display("FAIL rr_first_snapshot got=%h exp=%h", tr_out[n1], DATA_A); end
            checks++; if (tr_req[n1+1] || !tr_req[n1+2]) begin errors++; $display("FAIL rr_gap req=%b,%b exp=0,1", tr_req[n1+1], tr_req[n1+2]); end
            checks++; if (count_ack() != 2) begin errors++; $display("FAIL rr_ack_count got=%0d exp=2", count_ack()); end
            checks++; if (count_ns() != 2) begin errors++; $display("FAIL rr_ns_count got=%0d exp=2", count_ns()); end
            checks++; if (out1 !== DATA_D) begin errors++; $display("FAIL rr_second_snapshot got=%h exp=%h", out1, DATA_D); end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_read();
        bit got; int r;
        repeat (2) tick();
        load_mem(DATA_A);
        clear_trace();
        raise = 1'b1;
        run_until_addr(8'hA4, 40, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rst_reach_a4 got=0 exp=1"); end
        else begin
            raise = 1'b1;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            r = tr_addr.size() - 1;
            checks++; if (tr_req[r] || tr_addr[r] !== 8'hFF) begin errors++; $display("FAIL rst_bus req=%b addr=%h exp=0/ff", tr_req[r], tr_addr[r]); end
            checks++; if (tr_out[r] !== 48'h0) begin errors++; $display("FAIL rst_outputs got=%h exp=0", tr_out[r]); end
            tick();
            checks++; if (!tr_req[r+1]) begin errors++; $display("FAIL rst_rerequest got=0 exp=1"); end
            run_until_ns(40, got);
            checks++;
            if (!got) begin errors++; $display("FAIL rst_ns_timeout got=0 exp=1"); end
            else begin
                checks++; if (count_ack() != 2) begin errors++; $display("FAIL rst_ack_count got=%0d exp=2", count_ack()); end
                checks++; if (out1 !== DATA_A) begin errors++; $display("FAIL rst_snapshot got=%h exp=%h", out1, DATA_A); end
            end
        end
        $display("test_reset_mid_read done");
    endtask

    task automatic test_param_variant();
        logic [7:0] a2 [$];
        int f, n, acks;
        bit got;
        logic [47:0] exp2;
        exp2 = 48'h12_34_56_78_9A_BC;
        for (int i = 0; i < 6; i++) mem2[i] = exp2[47 - 8*i -: 8];
        got = 1'b0; acks = 0; f = -1; n = 0;
        raise2 = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            a2.push_back(addr2);
            if (ack2 === 1'b1) acks++;
            if (f < 0 && addr2 !== 8'hFF) f = i;
            if (ns2 === 1'b1) begin got = 1'b1; n = i; end
        end
        checks++;
        if (!got || f < 0) begin errors++; $display("FAIL param_ns_timeout got=0 exp=1"); end
        else begin
            checks++; if (n - f != 18) begin errors++; $display("FAIL param_latency got=%0d exp=18", n - f); end
            for (int k = 0; k < 18; k++) begin
                checks++;
                if (a2[f+k] !== 8'hB0 + 8'(k/3)) begin
                    errors++; $display("FAIL param_addr[%0d] got=%h exp=%h", k, a2[f+k], 8'hB0 + 8'(k/3));
                end
            end
            checks++; if (acks != 1) begin errors++; $display("FAIL param_ack_count got=%0d exp=1", acks); end
            checks++; if (out2 !== exp2) begin errors++; $display("FAIL param_snapshot got=%h exp=%h", out2, exp2); end
        end
        $display("test_param_variant done");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout reached=1 exp=0");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_delayed_grant();
        test_grant_drop();
        test_back_to_back();
        test_reset_mid_read();
        test_param_variant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
